// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared constants and types for the two-stage RV32I core front end:
// execute-stage opcode[6:2] encodings, the PC sequencer state type, and the
// priority ranking used when a redirect is buffered.
// -----------------------------------------------------------------------------
package core_pkg;

    localparam logic [4:0]  OP_JAL    = 5'b11011;
    localparam logic [4:0]  OP_JALR   = 5'b11001;
    localparam logic [4:0]  OP_BRANCH = 5'b11000;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    // Ordered so that a numerically larger value wins over a buffered one.
    typedef enum logic [1:0] {
        PRI_NONE = 2'd0,
        PRI_JB   = 2'd1,
        PRI_MRET = 2'd2,
        PRI_TRAP = 2'd3
    } redirect_pri_t;

endpackage

// File: rtl/next_pc_sel.sv
// -----------------------------------------------------------------------------
// next_pc_sel
// Combinational priority mux for the PC sequencer: trap > mret > jump/branch.
// Ports:
//   ignore        in   execute instruction is a bubble; only a trap is honoured
//   branch_taken  in   branch unit taken flag
//   opcode        in   execute-stage opcode[6:2]
//   iadder        in   jump/branch target
//   trap_taken    in   trap request
//   trap_addr     in   trap vector
//   mret          in   MRET in execute
//   epc           in   MRET return address
//   target        out  selected redirect address
//   redirect      out  a redirect is requested this cycle
//   pri           out  rank of the selected request
//   misaligned    out  taken jump/branch target has bit1 set (no redirect)
// -----------------------------------------------------------------------------
module next_pc_sel
    import core_pkg::*;
(
    input  logic          ignore,
    input  logic          branch_taken,
    input  logic [4:0]    opcode,
    input  logic [31:0]   iadder,
    input  logic          trap_taken,
    input  logic [31:0]   trap_addr,
    input  logic          mret,
    input  logic [31:0]   epc,
    output logic [31:0]   target,
    output logic          redirect,
    output redirect_pri_t pri,
    output logic          misaligned
);

    logic jb_taken;

    assign jb_taken = branch_taken || (opcode == OP_JAL) || (opcode == OP_JALR);

    always_comb begin
        target     = '0;
        redirect   = 1'b0;
        pri        = PRI_NONE;
        misaligned = 1'b0;
        if (trap_taken) begin
            target   = trap_addr;
            redirect = 1'b1;
            pri      = PRI_TRAP;
        end else if (!ignore) begin
            if (mret) begin
                target   = epc;
                redirect = 1'b1;
                pri      = PRI_MRET;
            end else if (jb_taken) begin
                // A misaligned target is reported and left for the CSR unit
                // to turn into a trap; it is never issued as a fetch address.
                if (iadder[1]) begin
                    misaligned = 1'b1;
                end else begin
                    target   = iadder;
                    redirect = 1'b1;
                    pri      = PRI_JB;
                end
            end
        end
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// pc_redirect_ctrl
// Program-counter sequencer: owns the fetch address and execute-stage PC,
// selects the next PC, produces a one-cycle flush after each redirect and
// buffers a redirect across fetch / data-memory stalls.
// Ports:
//   clk_in, rst_n_in       clock, async active-low reset
//   branch_taken_in        branch unit taken flag
//   opcode_6_2_in          execute-stage opcode[6:2]
//   iadder_in              jump/branch target
//   trap_taken_in/addr_in  trap request and vector
//   mret_in/epc_in         MRET request and return address
//   instr_hready_in        instruction memory handshake
//   stall_in               data-memory stall
//   imaddr_out             fetch address
//   pc_out/pc_plus_4_out   execute-stage PC and link value
//   flush_out              execute-stage instruction is a bubble
//   misaligned_instr_out   taken target has bit1 set (combinational)
//
// state | meaning
// RESET | just out of reset, execute slot is a bubble
// RUN   | normal sequential advance
// HOLD  | redirect buffered in pend_addr, waiting for an advance cycle
// FLUSH | one bubble cycle after a redirect
// -----------------------------------------------------------------------------
module pc_redirect_ctrl
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        branch_taken_in,
    input  logic [4:0]  opcode_6_2_in,
    input  logic [31:0] iadder_in,
    input  logic        trap_taken_in,
    input  logic [31:0] trap_addr_in,
    input  logic        mret_in,
    input  logic [31:0] epc_in,
    input  logic        instr_hready_in,
    input  logic        stall_in,
    output logic [31:0] imaddr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus_4_out,
    output logic        flush_out,
    output logic        misaligned_instr_out
);

    state_t        state, state_nxt;
    logic [31:0]   imaddr, imaddr_nxt;
    logic [31:0]   pc;
    logic [31:0]   pend_addr, pend_addr_nxt;
    redirect_pri_t pend_pri, pend_pri_nxt;
    logic          hold_bubble, hold_bubble_nxt;

    logic [31:0]   sel_target;
    logic          sel_redirect;
    redirect_pri_t sel_pri;
    logic          advance;
    logic          upgrade;
    logic [31:0]   held_target;
    redirect_pri_t held_pri;

    assign advance = instr_hready_in && !stall_in;

    // A HOLD entered from a bubble slot keeps reporting the bubble, so
    // flush_out does not drop while the pipeline is frozen.
    assign flush_out = (state == RESET) || (state == FLUSH) ||
                       ((state == HOLD) && hold_bubble);

    next_pc_sel u_next_pc_sel (
        .ignore       (flush_out),
        .branch_taken (branch_taken_in),
        .opcode       (opcode_6_2_in),
        .iadder       (iadder_in),
        .trap_taken   (trap_taken_in),
        .trap_addr    (trap_addr_in),
        .mret         (mret_in),
        .epc          (epc_in),
        .target       (sel_target),
        .redirect     (sel_redirect),
        .pri          (sel_pri),
        .misaligned   (misaligned_instr_out)
    );

    // Only a strictly higher-ranked request displaces the buffered one.
    assign upgrade     = sel_redirect && (sel_pri > pend_pri);
    assign held_target = upgrade ? sel_target : pend_addr;
    assign held_pri    = upgrade ? sel_pri    : pend_pri;

    always_comb begin
        state_nxt       = state;
        imaddr_nxt      = imaddr + 32'd4;
        pend_addr_nxt   = pend_addr;
        pend_pri_nxt    = pend_pri;
        hold_bubble_nxt = hold_bubble;
        case (state)
            RESET, RUN, FLUSH: begin
                if (sel_redirect) begin
                    if (advance) begin
                        state_nxt  = FLUSH;
                        imaddr_nxt = sel_target;
                    end else begin
                        state_nxt       = HOLD;
                        pend_addr_nxt   = sel_target;
                        pend_pri_nxt    = sel_pri;
                        hold_bubble_nxt = flush_out;
                    end
                end else if (state == RESET) begin
                    state_nxt = RUN;
                end else if ((state == FLUSH) && advance) begin
                    state_nxt = RUN;
                end
            end
            HOLD: begin
                if (advance) begin
                    state_nxt    = FLUSH;
                    imaddr_nxt   = held_target;
                    pend_pri_nxt = PRI_NONE;
                end else begin
                    pend_addr_nxt = held_target;
                    pend_pri_nxt  = held_pri;
                end
            end
            default: state_nxt = RESET;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state       <= RESET;
            imaddr      <= RESET_VECTOR;
            pc          <= RESET_VECTOR;
            pend_addr   <= '0;
            pend_pri    <= PRI_NONE;
            hold_bubble <= 1'b0;
        end else begin
            state       <= state_nxt;
            pend_addr   <= pend_addr_nxt;
            pend_pri    <= pend_pri_nxt;
            hold_bubble <= hold_bubble_nxt;
            if (advance) begin
                pc     <= imaddr;
                imaddr <= imaddr_nxt;
            end
        end
    end

    assign imaddr_out    = imaddr;
    assign pc_out        = pc;
    assign pc_plus_4_out = pc + 32'd4;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
module tb_pc_redirect_ctrl;

    localparam logic [4:0] OPC_JAL  = 5'b11011;
    localparam logic [4:0] OPC_JALR = 5'b11001;
    localparam logic [4:0] OPC_BR   = 5'b11000;
    localparam logic [4:0] OPC_ALU  = 5'b01100;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        branch_taken_in = 1'b0;
    logic [4:0]  opcode_6_2_in = OPC_ALU;
    logic [31:0] iadder_in = '0;
    logic        trap_taken_in = 1'b0;
    logic [31:0] trap_addr_in = '0;
    logic        mret_in = 1'b0;
    logic [31:0] epc_in = '0;
    logic        instr_hready_in = 1'b1;
    logic        stall_in = 1'b0;
    logic [31:0] imaddr_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus_4_out;
    logic        flush_out;
    logic        misaligned_instr_out;

    pc_redirect_ctrl #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk_in               (clk_in),
        .rst_n_in             (rst_n_in),
        .branch_taken_in      (branch_taken_in),
        .opcode_6_2_in        (opcode_6_2_in),
        .iadder_in            (iadder_in),
        .trap_taken_in        (trap_taken_in),
        .trap_addr_in         (trap_addr_in),
        .mret_in              (mret_in),
        .epc_in               (epc_in),
        .instr_hready_in      (instr_hready_in),
        .stall_in             (stall_in),
        .imaddr_out           (imaddr_out),
        .pc_out               (pc_out),
        .pc_plus_4_out        (pc_plus_4_out),
        .flush_out            (flush_out),
        .misaligned_instr_out (misaligned_instr_out)
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;

    // Reference model: fetch address, execute PC, bubble flag, and an
    // optional pending redirect ranked 1=jump/branch, 2=mret, 3=trap.
    logic [31:0] m_imaddr, m_pc, m_pend;
    int          m_pend_pri;
    bit          m_flush, m_first;
    logic        mis_obs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_imaddr   = 32'h0;
        m_pc       = 32'h0;
        m_pend     = 32'h0;
        m_pend_pri = 0;
        m_flush    = 1'b1;
        m_first    = 1'b1;
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".imaddr"}, imaddr_out, m_imaddr);
        check({tag, ".pc"}, pc_out, m_pc);
        check({tag, ".pc4"}, pc_plus_4_out, m_pc + 32'd4);
        check({tag, ".flush"}, {31'd0, flush_out}, {31'd0, m_flush});
    endtask

    // Drives one cycle of inputs just after a falling edge, checks the
    // combinational flag, advances the model, then checks registers at the
    // next falling edge.
    task automatic step(input string tag, input logic br, input logic [4:0] op,
                        input logic [31:0] tgt, input logic trap, input logic [31:0] taddr,
                        input logic mret, input logic [31:0] epc, input logic hr, input logic st);
        int          rp;
        logic [31:0] rt;
        bit          mis, adv;
        branch_taken_in = br;
        opcode_6_2_in   = op;
        iadder_in       = tgt;
        trap_taken_in   = trap;
        trap_addr_in    = taddr;
        mret_in         = mret;
        epc_in          = epc;
        instr_hready_in = hr;
        stall_in        = st;
        #1;
        rp  = 0;
        rt  = 32'h0;
        mis = 1'b0;
        if (trap) begin
            rp = 3; rt = taddr;
        end else if (!m_flush) begin
            if (mret) begin
                rp = 2; rt = epc;
            end else if (br || op == OPC_JAL || op == OPC_JALR) begin
                if (tgt[1]) mis = 1'b1;
                else begin rp = 1; rt = tgt; end
            end
        end
        mis_obs = misaligned_instr_out;
        check({tag, ".mis"}, {31'd0, misaligned_instr_out}, {31'd0, mis});
        adv = hr && !st;
        if (m_pend_pri != 0) begin
            if (rp > m_pend_pri) begin m_pend = rt; m_pend_pri = rp; end
            if (adv) begin
                m_pc = m_imaddr; m_imaddr = m_pend; m_flush = 1'b1; m_pend_pri = 0;
            end
        end else if (rp != 0) begin
            if (adv) begin
                m_pc = m_imaddr; m_imaddr = rt; m_flush = 1'b1;
            end else begin
                m_pend = rt; m_pend_pri = rp;
            end
        end else if (adv) begin
            m_pc = m_imaddr; m_imaddr = m_imaddr + 32'd4; m_flush = 1'b0;
        end else if (m_first) begin
            m_flush = 1'b0;
        end
        m_first = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        check_regs(tag);
    endtask

    task automatic seq(input string tag, input int n);
        for (int i = 0; i < n; i++)
            step(tag, 1'b0, OPC_ALU, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic br_to(input string tag, input logic [31:0] tgt, input logic hr, input logic st);
        step(tag, 1'b1, OPC_BR, tgt, 1'b0, 32'h0, 1'b0, 32'h0, hr, st);
    endtask

    task automatic trap_to(input string tag, input logic [31:0] tgt, input logic hr);
        step(tag, 1'b0, OPC_ALU, 32'h0, 1'b1, tgt, 1'b0, 32'h0, hr, 1'b0);
    endtask

    initial begin
        logic [4:0]  ops[4];
        logic [31:0] r_tgt, r_trap, r_epc;
        ops[0] = OPC_JAL; ops[1] = OPC_JALR; ops[2] = OPC_BR; ops[3] = OPC_ALU;

        model_reset();
        repeat (2) @(negedge clk_in);
        check_regs("reset");
        check("reset.mis", {31'd0, misaligned_instr_out}, 32'd0);
        check("reset.pc4_const", pc_plus_4_out, 32'h4);
        rst_n_in = 1'b1;

        seq("seq", 1);
        check("seq.first_flush_gone", {31'd0, flush_out}, 32'd0);
        check("seq.imaddr4", imaddr_out, 32'h4);
        seq("seq", 8);
        check("seq.pc20", pc_out, 32'h20);

        br_to("beq", 32'h100, 1'b1, 1'b0);
        check("beq.imaddr", imaddr_out, 32'h100);
        check("beq.flush", {31'd0, flush_out}, 32'd1);
        seq("beq_after", 1);
        check("beq.pc", pc_out, 32'h100);
        check("beq.noflush", {31'd0, flush_out}, 32'd0);

        step("jalr_mis", 1'b0, OPC_JALR, 32'h202, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("jalr.mis_seen", {31'd0, mis_obs}, 32'd1);
        check("jalr.seq", imaddr_out, 32'h108);
        trap_to("trap40", 32'h40, 1'b1);
        check("trap40.imaddr", imaddr_out, 32'h40);
        seq("trap40_after", 1);

        for (int i = 0; i < 3; i++) br_to("stall", 32'h300, 1'b1, 1'b1);
        check("stall.imaddr_held", imaddr_out, 32'h44);
        check("stall.pc_held", pc_out, 32'h40);
        br_to("stall_rel", 32'h300, 1'b1, 1'b0);
        check("stall.imaddr300", imaddr_out, 32'h300);
        seq("stall_after", 1);
        check("stall.one_flush", {31'd0, flush_out}, 32'd0);

        br_to("hold_br", 32'h500, 1'b0, 1'b0);
        trap_to("hold_trap", 32'h40, 1'b0);
        br_to("hold_rel", 32'h500, 1'b1, 1'b0);
        check("hold.trap_wins", imaddr_out, 32'h40);
        seq("hold_after", 1);
        trap_to("held_trap", 32'h80, 1'b0);
        br_to("held_br", 32'h600, 1'b0, 1'b0);
        br_to("held_rel", 32'h600, 1'b1, 1'b0);
        check("held.trap_kept", imaddr_out, 32'h80);
        seq("held_after", 1);

        br_to("wrap_br", 32'hFFFF_FFFC, 1'b1, 1'b0);
        seq("wrap", 1);
        check("wrap.imaddr", imaddr_out, 32'h0);
        check("wrap.pc4", pc_plus_4_out, 32'h0);
        seq("wrap_after", 2);

        br_to("rst_hold", 32'h700, 1'b1, 1'b1);
        #2 rst_n_in = 1'b0;
        #1;
        model_reset();
        check_regs("rst_async");
        check("rst_async.imaddr0", imaddr_out, 32'h0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        seq("rst_restart", 2);
        check("rst_restart.imaddr", imaddr_out, 32'h8);

        for (int n = 0; n < 500; n++) begin
            r_tgt = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) r_tgt = 32'hFFFF_FFF8;
            if ($urandom_range(0, 6) == 0) r_tgt = r_tgt | 32'h2;
            r_trap = $urandom & 32'hFFFF_FFFC;
            r_epc  = $urandom & 32'hFFFF_FFFC;
            step("rand", ($urandom_range(0, 4) == 0), ops[$urandom_range(0, 3)], r_tgt,
                 ($urandom_range(0, 15) == 0), r_trap, ($urandom_range(0, 11) == 0), r_epc,
                 ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Program-counter sequencer for the two-stage RV32I core. It owns the fetch address and the execute-stage PC, and consumes the branch unit's taken decision, the adder target, trap and MRET requests. It then picks the next PC, generates the one-cycle pipeline flush after every redirect, and holds or buffers a redirect across fetch and data-memory stalls.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.

Ports:
- clk_in  in  1  core clock.
- rst_n_in  in  1  reset; one clock; reset is asynchronous and active-low.
- branch_taken_in  in  1  taken flag from the branch unit, for the execute-stage instruction.
- opcode_6_2_in  in  5  execute-stage opcode[6:2]; JAL=5'b11011, JALR=5'b11001.
- iadder_in  in  32  branch/jump target (JALR bit0 already cleared).
- trap_taken_in  in  1  CSR unit requests trap entry.
- trap_addr_in  in  32  trap vector.
- mret_in  in  1  MRET in execute.
- epc_in  in  32  return address for MRET.
- instr_hready_in  in  1  instruction memory accepted imaddr_out and returned data this cycle.
- stall_in  in  1  data-memory stall; freezes the pipeline.
- imaddr_out  out  32  fetch address.
- pc_out  out  32  PC of the instruction now in execute.
- pc_plus_4_out  out  32  pc_out + 4 (link value).
- flush_out  out  1  the execute-stage instruction is a bubble.
- misaligned_instr_out  out  1  taken target has bit1 set.

## Operation
- Redirect priority: trap_taken_in > mret_in > jump/branch > sequential.
- A jump/branch is taken when branch_taken_in=1, or opcode is JAL or JALR.
- Requests are ignored while flush_out=1, because the execute instruction is a bubble. trap_taken_in is never ignored.
- A taken jump/branch with iadder_in[1]=1 raises misaligned_instr_out combinationally in that cycle and performs no redirect. The CSR unit answers with trap_taken_in.
- Sequential: imaddr_out += 4 and pc_out <= imaddr_out on each advance cycle.
- An advance cycle requires instr_hready_in=1 and stall_in=0.
- All arithmetic is mod 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

FSM states:
- RESET: entered on rst_n_in low. Next cycle → RUN.
- RUN: normal advance. A redirect with advance → FLUSH. A redirect without advance → HOLD, with the target latched in pend_addr.
- HOLD: pipeline frozen, redirect buffered. On advance → FLUSH.
- FLUSH: one bubble cycle, flush_out=1. If hready is low, stay in FLUSH. Otherwise → RUN.

Buffering rules:
- A higher-priority request arriving in HOLD overwrites pend_addr, e.g. a trap over a buffered branch.
- A lower-priority request does not overwrite pend_addr.
- Reset mid-operation discards pend_addr and any state. All outputs return to reset values asynchronously.

## Timing
- Reset values:
  - imaddr_out = RESET_VECTOR
  - pc_out = RESET_VECTOR
  - pc_plus_4_out = RESET_VECTOR+4
  - flush_out = 1
  - misaligned_instr_out = 0
  - state = RESET
- Redirect decided in cycle N (with advance):
  - imaddr_out = target in N+1.
  - flush_out = 1 in N+1.
  - pc_out = target with flush_out=0 in N+2.
- Redirect buffered in HOLD: the same N+1/N+2 sequence counts from the first advance cycle.
- misaligned_instr_out: combinational, same cycle as the taken decision. It is never registered.
- Stall: all registers hold their values. flush_out holds its value.

## Structure
- A shared package core_pkg holds the opcode constants (OP_JAL, OP_JALR, OP_BRANCH), the state typedef {RESET, RUN, HOLD, FLUSH}, and RESET_VECTOR default.
- One natural sub-module, next_pc_sel: a combinational priority mux producing target and a redirect flag.
- The FSM and registers stay in the top module.

## Test plan
- Reset release, hready=1 constantly → imaddr 0,4,8…; flush_out=1 for the first cycle only; pc_out trails imaddr_out by one cycle.
- BEQ taken to 32'h100 at pc_out=32'h20 → imaddr_out=32'h100 next cycle with flush_out=1; pc_out=32'h100 after that.
- JALR with iadder_in=32'h202 → misaligned_instr_out=1 same cycle; imaddr_out continues sequentially. Then trap_taken_in with trap_addr_in=32'h40 → redirect to 32'h40.
- Branch taken to 32'h300 while stall_in=1 for 3 cycles → all registers held; imaddr_out=32'h300 the cycle after stall_in falls; exactly one flush cycle.
- Branch buffered in HOLD, then trap_taken_in to 32'h40 arrives → redirect to 32'h40, not the branch target. A branch arriving during a held trap does not displace it.
- rst_n_in pulsed low mid-HOLD → outputs return to reset values immediately; fetch restarts at RESET_VECTOR; the buffered target is never issued.
